// File: rtl/fifo_sc_pkt_pkg.sv
// Shared constants and helpers for the single-clock packet FIFO.
package fifo_sc_pkt_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 64;
    localparam int unsigned CountWidth   = 16;

    typedef logic [CountWidth-1:0] count_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/dpMem_sc.sv
// Single-clock dual-port memory: synchronous write, read either combinational or
// registered on the read strobe.
module dpMem_sc #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter bit          ASYNC_READ = 1'b0
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [WIDTH-1:0]      wrData,
    input  logic                  rdEn,
    input  logic                  rdClr,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [WIDTH-1:0]      rdData
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    if (ASYNC_READ) begin : gAsyncRead
        // The strobe and clear only matter for the registered read port.
        logic unusedRdCtrl;
        assign unusedRdCtrl = rdEn ^ rdClr;
        assign rdData = mem[rdAddr];
    end else begin : gSyncRead
        logic [WIDTH-1:0] rdData_q;
        always_ff @(posedge clk) begin
            if (rdClr) begin
                rdData_q <= '0;
            end else if (rdEn) begin
                rdData_q <= mem[rdAddr];
            end
        end
        assign rdData = rdData_q;
    end

endmodule

// File: rtl/fifo_sc_pkt.sv
// Single-clock FIFO with optional FWFT reads and packet commit/rewind on the write side.
// Flags decode combinationally from the pointer registers; the element count is registered.
module fifo_sc_pkt
    import fifo_sc_pkt_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH    = DefaultWidth,
    parameter int unsigned FIFO_DEPTH    = DefaultDepth,
    parameter int unsigned ADDR_WIDTH    = clog2(FIFO_DEPTH),
    parameter int unsigned AFULL_THRESH  = 60,
    parameter int unsigned AEMPTY_THRESH = 4,
    parameter bit          FWFT          = 1'b0,
    parameter bit          PKT_MODE      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstSyncToClk,
    input  logic                  forceEmpty,
    input  logic [FIFO_WIDTH-1:0] dataIn,
    input  logic                  fifoWEn,
    input  logic                  pktCommit,
    input  logic                  pktRewind,
    output logic                  fifoFull,
    output logic                  fifoAlmostFull,
    output logic [FIFO_WIDTH-1:0] dataOut,
    input  logic                  fifoREn,
    output logic                  fifoEmpty,
    output logic                  fifoAlmostEmpty,
    output logic [CountWidth-1:0] numElementsInFifo,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PtrWidth = ADDR_WIDTH + 1;

    typedef logic [PtrWidth-1:0] ptr_t;

    localparam ptr_t DepthPtr = ptr_t'(FIFO_DEPTH);

    ptr_t   wrPtr_q, wrPtr_d;
    ptr_t   cmPtr_q, cmPtr_d;
    ptr_t   rdPtr_q, rdPtr_d;
    ptr_t   wrPtrNext;
    ptr_t   totalCnt, commitCnt;
    count_t numElements_q;
    logic   overflow_q, underflow_q;
    logic   flush, rewindEff, commitEff;
    logic   wrAccept, rdAccept, wrDropped, rdDropped;

    // Wrap-bit pointer arithmetic makes the differences exact occupancies.
    assign totalCnt  = wrPtr_q - rdPtr_q;
    assign commitCnt = cmPtr_q - rdPtr_q;

    assign fifoFull        = (totalCnt == DepthPtr);
    assign fifoEmpty       = (commitCnt == '0);
    assign fifoAlmostFull  = (32'(totalCnt) >= AFULL_THRESH);
    assign fifoAlmostEmpty = (32'(commitCnt) <= AEMPTY_THRESH);

    always_comb begin
        flush     = rstSyncToClk | forceEmpty;
        rewindEff = PKT_MODE & pktRewind;
        commitEff = PKT_MODE ? (pktCommit & ~pktRewind) : 1'b1;
        // A write that meets a rewind is discarded outright, so it is never an overflow.
        wrAccept  = fifoWEn & ~fifoFull & ~rewindEff & ~flush;
        wrDropped = fifoWEn & fifoFull & ~rewindEff;
        rdAccept  = fifoREn & ~fifoEmpty & ~flush;
        rdDropped = fifoREn & fifoEmpty;
        wrPtrNext = wrPtr_q + ptr_t'(wrAccept);
        wrPtr_d   = rewindEff ? cmPtr_q : wrPtrNext;
        cmPtr_d   = commitEff ? wrPtrNext : cmPtr_q;
        rdPtr_d   = rdPtr_q + ptr_t'(rdAccept);
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wrPtr_q       <= '0;
            cmPtr_q       <= '0;
            rdPtr_q       <= '0;
            numElements_q <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            cmPtr_q       <= cmPtr_d;
            rdPtr_q       <= rdPtr_d;
            numElements_q <= count_t'(commitCnt);
            if (wrDropped) begin
                overflow_q <= 1'b1;
            end
            if (rdDropped) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign numElementsInFifo = numElements_q;
    assign overflow          = overflow_q;
    assign underflow         = underflow_q;

    dpMem_sc #(
        .WIDTH      (FIFO_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ASYNC_READ (FWFT)
    ) uMem (
        .clk    (clk),
        .wrEn   (wrAccept),
        .wrAddr (wrPtr_q[ADDR_WIDTH-1:0]),
        .wrData (dataIn),
        .rdEn   (rdAccept),
        .rdClr  (flush),
        .rdAddr (rdPtr_q[ADDR_WIDTH-1:0]),
        .rdData (dataOut)
    );

endmodule

// File: tb/tb_fifo_sc_pkt.sv
// Bench for fifo_sc_pkt: a registered-read stream instance (index 0) and an FWFT packet
// instance (index 1) share stimulus and are compared against a queue-level model.
module tb_fifo_sc_pkt;

    logic        clk;
    logic        rstSyncToClk, forceEmpty, fifoWEn, fifoREn, pktCommit, pktRewind;
    logic [7:0]  dataIn;
    logic        full [2];
    logic        afull [2];
    logic        empty [2];
    logic        aempty [2];
    logic        ovf [2];
    logic        udf [2];
    logic [7:0]  dout [2];
    logic [15:0] cnt [2];

    int total, bad;

    // Model: committed and speculative word lists, kept in arrival order.
    logic [7:0] mCw [2][64];
    logic [7:0] mSw [2][64];
    int         mCn [2];
    int         mSn [2];
    bit         mOvf [2];
    bit         mUdf [2];
    logic [7:0] mDout [2];
    int         mCnt [2];

    fifo_sc_pkt #(.FWFT(1'b0), .PKT_MODE(1'b0)) dutR (
        .clk(clk), .rstSyncToClk(rstSyncToClk), .forceEmpty(forceEmpty), .dataIn(dataIn),
        .fifoWEn(fifoWEn), .pktCommit(pktCommit), .pktRewind(pktRewind), .fifoFull(full[0]),
        .fifoAlmostFull(afull[0]), .dataOut(dout[0]), .fifoREn(fifoREn), .fifoEmpty(empty[0]),
        .fifoAlmostEmpty(aempty[0]), .numElementsInFifo(cnt[0]), .overflow(ovf[0]),
        .underflow(udf[0])
    );

    fifo_sc_pkt #(.FWFT(1'b1), .PKT_MODE(1'b1)) dutP (
        .clk(clk), .rstSyncToClk(rstSyncToClk), .forceEmpty(forceEmpty), .dataIn(dataIn),
        .fifoWEn(fifoWEn), .pktCommit(pktCommit), .pktRewind(pktRewind), .fifoFull(full[1]),
        .fifoAlmostFull(afull[1]), .dataOut(dout[1]), .fifoREn(fifoREn), .fifoEmpty(empty[1]),
        .fifoAlmostEmpty(aempty[1]), .numElementsInFifo(cnt[1]), .overflow(ovf[1]),
        .underflow(udf[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelStep(input int d);
        bit isPkt, doRewind, doCommit, wasFull, wasEmpty;
        int prevCn;
        isPkt    = (d == 1);
        wasFull  = (mCn[d] + mSn[d]) == 64;
        wasEmpty = (mCn[d] == 0);
        prevCn   = mCn[d];
        if (rstSyncToClk || forceEmpty) begin
            mCn[d] = 0; mSn[d] = 0; mOvf[d] = 0; mUdf[d] = 0; mDout[d] = 8'h00; mCnt[d] = 0;
        end else begin
            doRewind = isPkt && pktRewind;
            doCommit = isPkt ? (pktCommit && !pktRewind) : 1'b1;
            if (fifoREn) begin
                if (wasEmpty) mUdf[d] = 1;
                else begin
                    if (d == 0) mDout[d] = mCw[d][0];
                    for (int i = 1; i < mCn[d]; i++) mCw[d][i-1] = mCw[d][i];
                    mCn[d]--;
                end
            end
            if (fifoWEn && !doRewind) begin
                if (wasFull) mOvf[d] = 1;
                else begin
                    mSw[d][mSn[d]] = dataIn;
                    mSn[d]++;
                end
            end
            if (doRewind) mSn[d] = 0;
            if (doCommit) begin
                for (int i = 0; i < mSn[d]; i++) mCw[d][mCn[d] + i] = mSw[d][i];
                mCn[d] += mSn[d];
                mSn[d] = 0;
            end
            mCnt[d] = prevCn;
        end
    endtask

    task automatic tick();
        modelStep(0);
        modelStep(1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input logic [7:0] d, input bit re, input bit cm,
                         input bit rw);
        fifoWEn = we; dataIn = d; fifoREn = re; pktCommit = cm; pktRewind = rw;
        tick();
        fifoWEn = 0; dataIn = 8'h00; fifoREn = 0; pktCommit = 0; pktRewind = 0;
    endtask

    task automatic flushAll();
        forceEmpty = 1;
        tick();
        forceEmpty = 0;
    endtask

    task automatic test_reset();
        rstSyncToClk = 1;
        fifoWEn = 1; dataIn = 8'h5A; fifoREn = 1;
        tick();
        tick();
        rstSyncToClk = 0; fifoWEn = 0; fifoREn = 0; dataIn = 8'h00;
        for (int d = 0; d < 2; d++) begin
            total++; if (empty[d] !== 1'b1) begin bad++; $display("FAIL reset_empty[%0d]: got %b want 1", d, empty[d]); end
            total++; if (aempty[d] !== 1'b1) begin bad++; $display("FAIL reset_aempty[%0d]: got %b want 1", d, aempty[d]); end
            total++; if (full[d] !== 1'b0) begin bad++; $display("FAIL reset_full[%0d]: got %b want 0", d, full[d]); end
            total++; if (afull[d] !== 1'b0) begin bad++; $display("FAIL reset_afull[%0d]: got %b want 0", d, afull[d]); end
            total++; if (cnt[d] !== 16'd0) begin bad++; $display("FAIL reset_cnt[%0d]: got %0d want 0", d, cnt[d]); end
            total++; if (ovf[d] !== 1'b0 || udf[d] !== 1'b0) begin bad++; $display("FAIL reset_sticky[%0d]: got %b%b want 00", d, ovf[d], udf[d]); end
        end
        total++; if (dout[0] !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout[0]); end
    endtask

    task automatic test_fill_drain();
        flushAll();
        for (int i = 1; i <= 64; i++) begin
            drive(1, 8'(i), 0, 0, 0);
            if (i == 59 || i == 60) begin
                total++; if (afull[0] !== (i >= 60)) begin bad++; $display("FAIL fill_afull@%0d: got %b want %b", i, afull[0], i >= 60); end
            end
            if (i == 63 || i == 64) begin
                total++; if (full[0] !== (i == 64)) begin bad++; $display("FAIL fill_full@%0d: got %b want %b", i, full[0], i == 64); end
            end
        end
        drive(1, 8'hEE, 0, 0, 0);
        total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL fill_overflow: got %b want 1", ovf[0]); end
        total++; if (full[0] !== 1'b1) begin bad++; $display("FAIL fill_full_after_drop: got %b want 1", full[0]); end
        for (int i = 1; i <= 64; i++) begin
            drive(0, 8'h00, 1, 0, 0);
            total++; if (dout[0] !== 8'(i)) begin bad++; $display("FAIL drain_data@%0d: got %h want %h", i, dout[0], 8'(i)); end
            total++; if (cnt[0] !== 16'(65 - i)) begin bad++; $display("FAIL drain_cnt@%0d: got %0d want %0d", i, cnt[0], 65 - i); end
        end
        total++; if (empty[0] !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", empty[0]); end
        total++; if (udf[0] !== 1'b0) begin bad++; $display("FAIL drain_underflow: got %b want 0", udf[0]); end
        drive(0, 8'h00, 0, 0, 0);
        total++; if (cnt[0] !== 16'd0) begin bad++; $display("FAIL drain_cnt_final: got %0d want 0", cnt[0]); end
    endtask

    task automatic test_spec_rewind();
        flushAll();
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'($urandom_range(0, 127)), 0, 0, 0);
            total++; if (empty[1] !== 1'b1) begin bad++; $display("FAIL spec_empty@%0d: got %b want 1", i, empty[1]); end
        end
        total++; if (cnt[1] !== 16'd0) begin bad++; $display("FAIL spec_cnt: got %0d want 0", cnt[1]); end
        drive(0, 8'h00, 0, 0, 1);
        drive(1, 8'hAA, 0, 1, 0);
        total++; if (empty[1] !== 1'b0) begin bad++; $display("FAIL rewind_commit_empty: got %b want 0", empty[1]); end
        total++; if (dout[1] !== 8'hAA) begin bad++; $display("FAIL rewind_data: got %h want aa", dout[1]); end
        drive(0, 8'h00, 0, 0, 0);
        total++; if (cnt[1] !== 16'd1) begin bad++; $display("FAIL rewind_cnt: got %0d want 1", cnt[1]); end
        drive(0, 8'h00, 1, 0, 0);
        total++; if (empty[1] !== 1'b1) begin bad++; $display("FAIL rewind_single_word: got %b want 1", empty[1]); end
    endtask

    task automatic test_commit_rewind();
        flushAll();
        for (int i = 1; i <= 5; i++) drive(1, 8'($urandom), 0, i == 5, 0);
        total++; if (empty[1] !== 1'b0) begin bad++; $display("FAIL commit_empty: got %b want 0", empty[1]); end
        drive(0, 8'h00, 0, 0, 0);
        total++; if (cnt[1] !== 16'd5) begin bad++; $display("FAIL commit_cnt: got %0d want 5", cnt[1]); end
        for (int i = 0; i < 3; i++) drive(1, 8'($urandom), 0, 0, 0);
        drive(0, 8'h00, 0, 1, 1);
        drive(0, 8'h00, 0, 1, 0);
        drive(0, 8'h00, 0, 0, 0);
        total++; if (cnt[1] !== 16'd5) begin bad++; $display("FAIL rewind_wins_cnt: got %0d want 5", cnt[1]); end
    endtask

    task automatic test_fwft_underflow();
        flushAll();
        drive(1, 8'h55, 0, 1, 0);
        total++; if (empty[1] !== 1'b0) begin bad++; $display("FAIL fwft_empty: got %b want 0", empty[1]); end
        total++; if (dout[1] !== 8'h55) begin bad++; $display("FAIL fwft_data: got %h want 55", dout[1]); end
        drive(0, 8'h00, 0, 0, 0);
        total++; if (dout[1] !== 8'h55 || empty[1] !== 1'b0) begin bad++; $display("FAIL fwft_hold: got %h/%b want 55/0", dout[1], empty[1]); end
        drive(0, 8'h00, 1, 0, 0);
        total++; if (empty[1] !== 1'b1) begin bad++; $display("FAIL fwft_pop_empty: got %b want 1", empty[1]); end
        total++; if (udf[1] !== 1'b0) begin bad++; $display("FAIL fwft_no_underflow: got %b want 0", udf[1]); end
        total++; if (dout[0] !== 8'h55) begin bad++; $display("FAIL reg_read_data: got %h want 55", dout[0]); end
        drive(0, 8'h00, 1, 0, 0);
        total++; if (udf[1] !== 1'b1) begin bad++; $display("FAIL fwft_underflow: got %b want 1", udf[1]); end
        total++; if (udf[0] !== 1'b1) begin bad++; $display("FAIL reg_underflow: got %b want 1", udf[0]); end
    endtask

    task automatic test_wrap();
        flushAll();
        for (int i = 0; i < 63; i++) drive(1, 8'($urandom), 0, 0, 0);
        total++; if (afull[0] !== 1'b1) begin bad++; $display("FAIL wrap_afull: got %b want 1", afull[0]); end
        for (int i = 0; i < 400; i++) begin
            drive(1, 8'($urandom), 1, 0, 0);
            total++; if (cnt[0] !== 16'd63) begin bad++; $display("FAIL wrap_cnt@%0d: got %0d want 63", i, cnt[0]); end
            total++; if (full[0] !== 1'b0) begin bad++; $display("FAIL wrap_full@%0d: got %b want 0", i, full[0]); end
            total++; if (dout[0] !== mDout[0]) begin bad++; $display("FAIL wrap_data@%0d: got %h want %h", i, dout[0], mDout[0]); end
        end
    endtask

    task automatic test_force_empty();
        flushAll();
        drive(0, 8'h00, 1, 0, 0);
        total++; if (udf[1] !== 1'b1) begin bad++; $display("FAIL fe_pre_underflow: got %b want 1", udf[1]); end
        for (int i = 1; i <= 20; i++) drive(1, (i == 1) ? 8'h11 : 8'($urandom), 0, i == 20, 0);
        for (int i = 0; i < 4; i++) drive(1, 8'($urandom), 0, 0, 0);
        forceEmpty = 1; fifoWEn = 1; dataIn = 8'h77; fifoREn = 1; pktCommit = 1;
        tick();
        forceEmpty = 0; fifoWEn = 0; dataIn = 8'h00; fifoREn = 0; pktCommit = 0;
        total++; if (empty[1] !== 1'b1 || aempty[1] !== 1'b1) begin bad++; $display("FAIL fe_empty: got %b%b want 11", empty[1], aempty[1]); end
        total++; if (full[1] !== 1'b0 || afull[1] !== 1'b0) begin bad++; $display("FAIL fe_full: got %b%b want 00", full[1], afull[1]); end
        total++; if (cnt[1] !== 16'd0) begin bad++; $display("FAIL fe_cnt: got %0d want 0", cnt[1]); end
        total++; if (udf[1] !== 1'b0 || ovf[1] !== 1'b0) begin bad++; $display("FAIL fe_sticky: got %b%b want 00", udf[1], ovf[1]); end
        drive(1, 8'h3C, 0, 1, 0);
        total++; if (dout[1] !== 8'h3C) begin bad++; $display("FAIL fe_resume_addr0: got %h want 3c", dout[1]); end
        drive(0, 8'h00, 0, 0, 0);
        total++; if (cnt[1] !== 16'd1) begin bad++; $display("FAIL fe_resume_cnt: got %0d want 1", cnt[1]); end
    endtask

    task automatic test_random();
        int wrBias;
        bit expE, expF, expAf, expAe;
        wrBias = 2;
        flushAll();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) wrBias = $urandom_range(1, 3);
            fifoWEn    = ($urandom_range(0, 3) < wrBias);
            fifoREn    = ($urandom_range(0, 3) >= wrBias);
            dataIn     = 8'($urandom);
            pktCommit  = ($urandom_range(0, 7) == 0);
            pktRewind  = ($urandom_range(0, 15) == 0);
            forceEmpty = ($urandom_range(0, 499) == 0);
            tick();
            for (int d = 0; d < 2; d++) begin
                expE  = (mCn[d] == 0);
                expF  = (mCn[d] + mSn[d] == 64);
                expAf = (mCn[d] + mSn[d] >= 60);
                expAe = (mCn[d] <= 4);
                total++; if (empty[d] !== expE) begin bad++; $display("FAIL rnd_empty[%0d]@%0d: got %b want %b", d, c, empty[d], expE); end
                total++; if (full[d] !== expF) begin bad++; $display("FAIL rnd_full[%0d]@%0d: got %b want %b", d, c, full[d], expF); end
                total++; if (afull[d] !== expAf) begin bad++; $display("FAIL rnd_afull[%0d]@%0d: got %b want %b", d, c, afull[d], expAf); end
                total++; if (aempty[d] !== expAe) begin bad++; $display("FAIL rnd_aempty[%0d]@%0d: got %b want %b", d, c, aempty[d], expAe); end
                total++; if (cnt[d] !== 16'(mCnt[d])) begin bad++; $display("FAIL rnd_cnt[%0d]@%0d: got %0d want %0d", d, c, cnt[d], mCnt[d]); end
                total++; if (ovf[d] !== mOvf[d] || udf[d] !== mUdf[d]) begin bad++; $display("FAIL rnd_sticky[%0d]@%0d: got %b%b want %b%b", d, c, ovf[d], udf[d], mOvf[d], mUdf[d]); end
            end
            total++; if (dout[0] !== mDout[0]) begin bad++; $display("FAIL rnd_reg_data@%0d: got %h want %h", c, dout[0], mDout[0]); end
            if (mCn[1] > 0) begin
                total++; if (dout[1] !== mCw[1][0]) begin bad++; $display("FAIL rnd_fwft_data@%0d: got %h want %h", c, dout[1], mCw[1][0]); end
            end
        end
        fifoWEn = 0; fifoREn = 0; pktCommit = 0; pktRewind = 0; forceEmpty = 0; dataIn = 8'h00;
    endtask

    initial begin
        total = 0; bad = 0;
        rstSyncToClk = 1; forceEmpty = 0; fifoWEn = 0; fifoREn = 0;
        pktCommit = 0; pktRewind = 0; dataIn = 8'h00;
        for (int d = 0; d < 2; d++) begin
            mCn[d] = 0; mSn[d] = 0; mOvf[d] = 0; mUdf[d] = 0; mDout[d] = 8'h00; mCnt[d] = 0;
        end
        test_reset();
        test_fill_drain();
        test_spec_rewind();
        test_commit_rewind();
        test_fwft_underflow();
        test_wrap();
        test_force_empty();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
